// File: rtl/wbc_arbiter.sv
// wbc_arbiter -- round-robin arbiter and watchdog for the shared control
// WISHBONE bus. Owns the master select (pcic=0, turfc=1, hkmc=2, wbvio=3),
// grants one master per cyc (non-preemptive) and synthesizes an err when a
// granted strobe waits TIMEOUT_CYCLES without ack/err/rty.
//
// Optional build macro: WBC_ARB_PCI_PRIORITY_EN
//   defined   : master 0 (PCI) always wins in IDLE; masters 1-3 round-robin.
//   undefined : pure 4-way round-robin.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   cyc_i, stb_i          per-master cyc/stb requests
//   ack_i, err_i, rty_i   terminations from the shared slave side
//   gnt_o, gnt_idx_o      registered one-hot grant / index of current-last grant
//   bus_cyc_o, bus_stb_o  granted master's cyc/stb towards the slave side
//   to_err_o, timeout_o   one-cycle watchdog err / event pulse
//   timeout_count_o       saturating count of watchdog events
module wbc_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int NMASTERS       = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NMASTERS-1:0] cyc_i,
    input  logic [NMASTERS-1:0] stb_i,
    input  logic                ack_i,
    input  logic                err_i,
    input  logic                rty_i,
    output logic [NMASTERS-1:0] gnt_o,
    output logic [1:0]          gnt_idx_o,
    output logic                bus_cyc_o,
    output logic                bus_stb_o,
    output logic [NMASTERS-1:0] to_err_o,
    output logic                timeout_o,
    output logic [15:0]         timeout_count_o
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN, TERR} state_e;

    state_e              state_q, state_d;
    logic [NMASTERS-1:0] gnt_q, gnt_d;
    logic [1:0]          gnt_idx_q, gnt_idx_d;
    logic [CW-1:0]       wd_cnt_q, wd_cnt_d;
    logic [NMASTERS-1:0] to_err_q, to_err_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         tcnt_q, tcnt_d;

    logic       term;
    logic       own_cyc;
    logic       own_stb;
    logic       sel_vld;
    logic [1:0] sel_idx;
    logic [1:0] cand;

    assign term    = ack_i | err_i | rty_i;
    assign own_cyc = cyc_i[gnt_idx_q];
    assign own_stb = stb_i[gnt_idx_q];

    // Next-owner search: first requester at last+1, +2, +3, +0 (mod 4).
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = gnt_idx_q;
        cand    = '0;
`ifdef WBC_ARB_PCI_PRIORITY_EN
        if (cyc_i[0]) begin
            sel_vld = 1'b1;
            sel_idx = 2'd0;
        end
`endif
        for (int i = 1; i <= NMASTERS; i++) begin
            cand = gnt_idx_q + 2'(i);
`ifdef WBC_ARB_PCI_PRIORITY_EN
            if (!sel_vld && cand != 2'd0 && cyc_i[cand]) begin
`else
            if (!sel_vld && cyc_i[cand]) begin
`endif
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        wd_cnt_d  = '0;
        to_err_d  = '0;
        timeout_d = 1'b0;
        tcnt_d    = tcnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (sel_vld) begin
                    gnt_d     = NMASTERS'(1) << sel_idx;
                    gnt_idx_d = sel_idx;
                    state_d   = OWN;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (own_stb && !term) begin
                    // A real termination on the terminal count wins, so the
                    // event only fires when this cycle is still unterminated.
                    if (wd_cnt_q == WD_LAST) begin
                        state_d   = TERR;
                        to_err_d  = gnt_q;
                        timeout_d = 1'b1;
                        if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            TERR: begin
                if (!own_cyc) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = OWN;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= 2'd3;
            wd_cnt_q  <= '0;
            to_err_q  <= '0;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            wd_cnt_q  <= wd_cnt_d;
            to_err_q  <= to_err_d;
            timeout_q <= timeout_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign gnt_o           = gnt_q;
    assign gnt_idx_o       = gnt_idx_q;
    assign to_err_o        = to_err_q;
    assign timeout_o       = timeout_q;
    assign timeout_count_o = tcnt_q;
    // The watchdog cycle hides the strobe so the slave never sees a new beat
    // while the synthesized err is being returned.
    assign bus_cyc_o = (|gnt_q) & own_cyc;
    assign bus_stb_o = (|gnt_q) & own_stb & (state_q != TERR);

endmodule

// File: tb/tb_wbc_arbiter.sv
// Testbench for wbc_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_wbc_arbiter;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  cyc_i = '0;
    logic [3:0]  stb_i = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        rty_i = 1'b0;
    logic [3:0]  gnt_o;
    logic [1:0]  gnt_idx_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic [3:0]  to_err_o;
    logic        timeout_o;
    logic [15:0] timeout_count_o;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner (-1 = none), last granted index, cycles waited,
    // watchdog-pulse cycle flag, event count.
    int m_own;
    int m_last;
    int m_wait;
    int m_cnt;
    bit m_terr;

    wbc_arbiter #(.TIMEOUT_CYCLES(TO), .NMASTERS(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
        .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
        .to_err_o(to_err_o), .timeout_o(timeout_o),
        .timeout_count_o(timeout_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] c, input int last);
        int r;
        r = -1;
`ifdef WBC_ARB_PCI_PRIORITY_EN
        if (c[0]) r = 0;
`endif
        for (int k = 1; k <= 4; k++) begin
            int m;
            m = (last + k) % 4;
`ifdef WBC_ARB_PCI_PRIORITY_EN
            if (r < 0 && m != 0 && c[m]) r = m;
`else
            if (r < 0 && c[m]) r = m;
`endif
        end
        return r;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_last = 3;
        m_wait = 0;
        m_cnt  = 0;
        m_terr = 1'b0;
    endtask

    task automatic model_update();
        int  p;
        bit  trm;
        trm = ack_i | err_i | rty_i;
        if (!rst_i) begin
            model_reset();
            return;
        end
        if (m_terr) begin
            m_terr = 1'b0;
            m_wait = 0;
            if (!cyc_i[m_own]) m_own = -1;
        end else if (m_own < 0) begin
            p = pick(cyc_i, m_last);
            if (p >= 0) begin
                m_own  = p;
                m_last = p;
            end
            m_wait = 0;
        end else if (!cyc_i[m_own]) begin
            m_own  = -1;
            m_wait = 0;
        end else if (stb_i[m_own] && !trm) begin
            if (m_wait == TO - 1) begin
                m_terr = 1'b1;
                m_wait = 0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
        end
    endtask

    // Called at a falling edge with inputs already driven: check outputs
    // against the model, advance one rising edge, update the model.
    task automatic tick();
        logic [3:0] eg;
        #1;
        eg = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
        chk("gnt",      32'(gnt_o),           32'(eg));
        chk("gnt_idx",  32'(gnt_idx_o),       32'(m_last));
        chk("to_err",   32'(to_err_o),        32'(m_terr ? eg : 4'b0));
        chk("timeout",  32'(timeout_o),       32'(m_terr));
        chk("to_count", 32'(timeout_count_o), 32'(m_cnt));
        chk("bus_cyc",  32'(bus_cyc_o),       32'((m_own >= 0) && cyc_i[m_own & 3]));
        chk("bus_stb",  32'(bus_stb_o),       32'((m_own >= 0) && !m_terr && stb_i[m_own & 3]));
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic idle_all();
        cyc_i = '0; stb_i = '0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int ord[5];
`ifdef WBC_ARB_PCI_PRIORITY_EN
        ord = '{0, 0, 0, 0, 0};
`else
        ord = '{0, 1, 2, 3, 0};
`endif
        model_reset();
        @(negedge clk_i);
        tick();
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_idx", 32'(gnt_idx_o), 32'h3);
        rst_i = 1'b1;
        tick();

        // All four request; each owner does a 5-cycle acked transfer and
        // drops cyc for one cycle before re-requesting.
        cyc_i = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", 32'(gnt_o), 32'(1 << ord[k]));
            stb_i = 4'hF;
            repeat (4) tick();
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            stb_i = '0;
            cyc_i[ord[k]] = 1'b0;
            tick();
            chk("rr_dead", 32'(gnt_o), 32'h0);
            cyc_i = 4'hF;
            tick();
        end
        idle_all();

        // Single requester: grant one cycle after cyc, release one after drop.
        cyc_i = 4'b0100;
        tick();
        chk("single_gnt", 32'(gnt_o), 32'h4);
        chk("single_idx", 32'(gnt_idx_o), 32'h2);
        repeat (9) tick();
        cyc_i = '0;
        tick();
        chk("single_rel", 32'(gnt_o), 32'h0);
        tick();

        // Ack on the terminal waiting cycle beats the watchdog.
        cyc_i = 4'b0010;
        tick();
        stb_i = 4'b0010;
        repeat (TO - 1) tick();
        ack_i = 1'b1;
        tick();
        chk("ack_win_err", 32'(to_err_o), 32'h0);
        chk("ack_win_cnt", 32'(timeout_count_o), 32'h0);
        ack_i = 1'b0;
        stb_i = '0;
        tick();

        // Unanswered strobe: err pulse exactly TO cycles after stb rise.
        stb_i = 4'b0010;
        repeat (TO - 1) tick();
        chk("to_early", 32'(to_err_o), 32'h0);
        tick();
        chk("to_err", 32'(to_err_o), 32'h2);
        chk("to_pulse", 32'(timeout_o), 32'h1);
        chk("to_stb_mask", 32'(bus_stb_o), 32'h0);
        tick();
        chk("to_count", 32'(timeout_count_o), 32'h1);
        chk("to_keep", 32'(gnt_o), 32'h2);
        chk("to_done", 32'(to_err_o), 32'h0);
        idle_all();

        // Asynchronous reset while master 3 owns the bus mid-transfer.
        cyc_i = 4'b1000;
        tick();
        chk("m3_gnt", 32'(gnt_o), 32'h8);
        stb_i = 4'b1000;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt_o), 32'h0);
        chk("arst_err", 32'(to_err_o), 32'h0);
        chk("arst_idx", 32'(gnt_idx_o), 32'h3);
        chk("arst_cnt", 32'(timeout_count_o), 32'h0);
        model_reset();
        cyc_i = 4'b1001;
        stb_i = '0;
        tick();
        rst_i = 1'b1;
        tick();
        chk("arst_first", 32'(gnt_o), 32'h1);

        // Last grant 0, requests 0111: PCI priority decides the winner.
        cyc_i = '0;
        tick();
        cyc_i = 4'b0111;
        tick();
`ifdef WBC_ARB_PCI_PRIORITY_EN
        chk("prio_next", 32'(gnt_o), 32'h1);
`else
        chk("prio_next", 32'(gnt_o), 32'h2);
`endif
        idle_all();

        // Randomized traffic with sticky cyc and sparse terminations.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(11) == 0) cyc_i[b] = ~cyc_i[b];
            for (int b = 0; b < 4; b++)
                stb_i[b] = ($urandom_range(7) != 0);
            ack_i = ($urandom_range(24) == 0);
            err_i = ($urandom_range(59) == 0);
            rty_i = ($urandom_range(59) == 0);
            tick();
        end
        idle_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wbc_arbiter.md
Name: wbc_arbiter

Overview:
- Round-robin arbiter and watchdog for the shared control WISHBONE bus.
- Sits in front of the control-bus interconnect and owns the master select: pcic=0, turfc=1, hkmc=2, wbvio=3.
- Grants one master at a time and holds the grant for the whole cyc.
- Terminates stalled transfers with a synthesized err so that one dead slave cannot lock the bus.

Parameters:
TIMEOUT_CYCLES, 1024, cycles a granted strobe may wait for ack/err/rty before the watchdog fires (min 2)
NMASTERS, 4, number of requesting masters (fixed at 4; the parameter exists for readability only)

Ports:
clk_i  input  1  control WISHBONE clock
rst_i  input  1  asynchronous, active-low reset
cyc_i  input  4  per-master cyc request
stb_i  input  4  per-master stb
ack_i  input  1  ack from the shared slave side
err_i  input  1  err from the shared slave side
rty_i  input  1  rty from the shared slave side
gnt_o  output  4  one-hot grant, registered
gnt_idx_o  output  2  binary index of the current/last grant, registered
bus_cyc_o  output  1  cyc_i[gnt_idx_o] gated by grant valid (combinational)
bus_stb_o  output  1  stb_i[gnt_idx_o] gated by grant valid (combinational)
to_err_o  output  4  one-cycle watchdog err to the granted master, registered
timeout_o  output  1  one-cycle pulse on each watchdog event
timeout_count_o  output  16  saturating count of watchdog events

Behaviour:
- Reset values (rst_i low, asynchronous):
  - gnt_o=0, gnt_idx_o=3 (so master 0 has first priority), to_err_o=0, timeout_o=0, timeout_count_o=0.
  - State=IDLE, watchdog counter=0.
- States: IDLE, OWN, TERR.
- IDLE:
  - gnt_o=0.
  - If any cyc_i bit is set, select the first requester searching gnt_idx_o+1, +2, +3, +0 (mod 4).
  - Register the selection into gnt_o/gnt_idx_o and go to OWN.
  - Latency: cyc_i rise at cycle n gives gnt_o at n+1.
  - No requests: stay in IDLE, gnt_idx_o unchanged.
- OWN:
  - gnt_o is held.
  - If cyc_i[g] is low, go to IDLE; gnt_o=0 from the next cycle.
  - This guarantees at least one dead cycle between owners. Handover is therefore cyc fall at n, new grant at n+2.
  - Other requests never preempt the owner.
- Watchdog, active in OWN only:
  - The counter increments each cycle that stb_i[g] is high and ack_i, err_i and rty_i are all low.
  - It clears on any termination, on stb_i[g] low, and on leaving OWN.
  - If the counter equals TIMEOUT_CYCLES-1 and there is no termination in the same cycle, go to TERR.
- TERR (one cycle):
  - to_err_o[g]=1 and timeout_o=1.
  - timeout_count_o increments, saturating at 16'hFFFF.
  - bus_stb_o is forced low this cycle.
  - Counter clears; return to OWN with the grant kept.
  - If cyc_i[g] is already low in TERR, to_err_o still pulses and the next state is IDLE.
- A real ack/err/rty arriving in the same cycle as the terminal count wins: no watchdog event.
- A termination arriving during TERR is ignored by the arbiter; the interconnect must block it.
- bus_cyc_o/bus_stb_o are 0 whenever gnt_o=0.
- A master that raises cyc_i while another master owns the bus waits. Its cyc_i is never observed by the slave side.
- Simultaneous requests from all four masters are served in the order idx+1 … idx+4 mod 4 across successive ownerships.

Optional Feature:
WBC_ARB_PCI_PRIORITY_EN
- Defined: in IDLE, cyc_i[0] (PCI) always wins if asserted; the remaining masters use round-robin among 1–3 only. gnt_idx_o still records the last grant. Ownership is still non-preemptive.
- Not defined: pure 4-way round-robin as described above.

Test Plan:
- Reset, then cyc_i=4'b1111 held with 5-cycle transfers acked each → grant order 0,1,2,3,0. Each gnt_o is one-hot, with one gnt_o=0 cycle between owners.
- cyc_i=4'b0100 at cycle 10 → gnt_o=4'b0100 and gnt_idx_o=2 at cycle 11; cyc_i drop at 20 → gnt_o=0 at 21.
- TIMEOUT_CYCLES=8, master 1 holds stb with no ack → to_err_o=4'b0010 and timeout_o pulse exactly 8 cycles after stb rise; timeout_count_o=1; grant retained.
- TIMEOUT_CYCLES=8, ack_i arrives on the 8th waiting cycle → no to_err_o, timeout_count_o stays 0.
- rst_i pulled low while master 3 owns the bus mid-transfer → gnt_o=0, to_err_o=0, gnt_idx_o=3 immediately. After release with cyc_i=4'b1001, master 0 is granted first.
- WBC_ARB_PCI_PRIORITY_EN, last grant 0, requests 4'b0111 → next grant is master 0 despite round-robin order; without the macro the next grant is master 1.
